// File: rtl/ysyx_24100012_mem_arbiter.sv
// Shares the single-port RAM between IFU (read-only) and LSU, one transaction at a time.
// Define YSYX_24100012_ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module ysyx_24100012_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [DATA_WIDTH-1:0] lsu_len,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [DATA_WIDTH-1:0] mem_len,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Valid/ready: a transfer happens in a cycle where both valid and ready are high at the
    // rising edge; valid must then stay high with stable payload until that cycle.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  owner_q, owner_d;  // 1 = LSU owns the transaction
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] len_q, len_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic grant_ifu, grant_lsu;
    logic accept, strobe, resp_hs;

`ifdef YSYX_24100012_ARB_RR_EN
    logic last_q, last_d;  // 1 = LSU was granted last

    always_comb begin
        grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_q);
        grant_ifu = ifu_req_valid && (!lsu_req_valid || last_q);
        last_d    = last_q;
        if (accept) begin
            last_d = lsu_req_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant_lsu = lsu_req_valid;
        grant_ifu = ifu_req_valid && !lsu_req_valid;
    end
`endif

    assign accept  = (ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready);
    assign strobe  = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    assign resp_hs = (state_q == S_RESP) && (owner_q ? lsu_resp_ready : ifu_resp_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_INIT;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Ready is held low while reset is asserted so nothing is accepted during reset.
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        mem_wen        = 1'b0;
        mem_ren        = 1'b0;
        mem_len        = '0;
        mem_waddr      = '0;
        mem_raddr      = '0;
        mem_wdata      = '0;
        if (state_q == S_IDLE && !rst) begin
            ifu_req_ready = grant_ifu;
            lsu_req_ready = grant_lsu;
        end
        if (strobe) begin
            mem_wen = wen_q;
            mem_ren = !wen_q;
            mem_len = len_q;
            if (wen_q) begin
                mem_waddr = addr_q;
                mem_wdata = wdata_q;
            end else begin
                mem_raddr = addr_q;
            end
        end
        if (state_q == S_RESP) begin
            if (owner_q) begin
                lsu_resp_valid = 1'b1;
                lsu_rdata      = rdata_q;
            end else begin
                ifu_resp_valid = 1'b1;
                ifu_rdata      = rdata_q;
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        len_d   = len_q;
        rdata_d = rdata_q;
        if (accept) begin
            owner_d = lsu_req_ready;
            if (lsu_req_ready) begin
                wen_d   = lsu_wen;
                addr_d  = lsu_addr;
                wdata_d = lsu_wdata;
                len_d   = lsu_len;
            end else begin
                wen_d   = 1'b0;
                addr_d  = ifu_addr;
                wdata_d = '0;
                len_d   = DATA_WIDTH'(4);
            end
        end
        if (strobe) begin
            rdata_d = wen_q ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24100012_mem_arbiter.sv
// Bench for ysyx_24100012_mem_arbiter: three instances (LATENCY 1, 3, 4) checked every cycle
// against a transaction-timestamp model; honours YSYX_24100012_ARB_RR_EN.
module tb_ysyx_24100012_mem_arbiter;

    localparam int ND = 3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] pre(input int i);
        return (i == 0) ? 32'h0000_0413 : {16'hA5A5, 16'(i)};
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid [ND];
    logic        ifu_req_ready [ND];
    logic [31:0] ifu_addr [ND];
    logic        ifu_resp_valid [ND];
    logic        ifu_resp_ready [ND];
    logic [31:0] ifu_rdata [ND];
    logic        lsu_req_valid [ND];
    logic        lsu_req_ready [ND];
    logic        lsu_wen [ND];
    logic [31:0] lsu_addr [ND];
    logic [31:0] lsu_wdata [ND];
    logic [31:0] lsu_len [ND];
    logic        lsu_resp_valid [ND];
    logic        lsu_resp_ready [ND];
    logic [31:0] lsu_rdata [ND];
    logic        mem_wen [ND];
    logic        mem_ren [ND];
    logic [31:0] mem_len [ND];
    logic [31:0] mem_waddr [ND];
    logic [31:0] mem_raddr [ND];
    logic [31:0] mem_wdata [ND];
    logic [31:0] mem_rdata [ND];
    logic [31:0] phys_ram [ND][128];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        assign mem_rdata[g] = phys_ram[g][mem_raddr[g][8:2]];
        ysyx_24100012_mem_arbiter #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .LATENCY   (lat_of(g))
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .ifu_req_valid (ifu_req_valid[g]),
            .ifu_req_ready (ifu_req_ready[g]),
            .ifu_addr      (ifu_addr[g]),
            .ifu_resp_valid(ifu_resp_valid[g]),
            .ifu_resp_ready(ifu_resp_ready[g]),
            .ifu_rdata     (ifu_rdata[g]),
            .lsu_req_valid (lsu_req_valid[g]),
            .lsu_req_ready (lsu_req_ready[g]),
            .lsu_wen       (lsu_wen[g]),
            .lsu_addr      (lsu_addr[g]),
            .lsu_wdata     (lsu_wdata[g]),
            .lsu_len       (lsu_len[g]),
            .lsu_resp_valid(lsu_resp_valid[g]),
            .lsu_resp_ready(lsu_resp_ready[g]),
            .lsu_rdata     (lsu_rdata[g]),
            .mem_wen       (mem_wen[g]),
            .mem_ren       (mem_ren[g]),
            .mem_len       (mem_len[g]),
            .mem_waddr     (mem_waddr[g]),
            .mem_raddr     (mem_raddr[g]),
            .mem_wdata     (mem_wdata[g]),
            .mem_rdata     (mem_rdata[g])
        );
    end

    // Reference model: one outstanding transaction per instance, described by its acceptance cycle.
    bit          m_busy [ND];
    int          m_acc [ND];
    bit          m_owner [ND];
    bit          m_wen [ND];
    logic [31:0] m_addr [ND];
    logic [31:0] m_wdata [ND];
    logic [31:0] m_len [ND];
    logic [31:0] m_data [ND];
    bit          m_last [ND];
    logic [31:0] ref_ram [ND][128];
    bit          acc_ifu [ND];
    bit          acc_lsu [ND];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input logic [197:0] act, input logic [197:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [197:0] outs(input int d);
        return {ifu_req_ready[d], lsu_req_ready[d], ifu_resp_valid[d], ifu_rdata[d],
                lsu_resp_valid[d], lsu_rdata[d], mem_wen[d], mem_ren[d], mem_len[d],
                mem_waddr[d], mem_raddr[d], mem_wdata[d]};
    endfunction

    task automatic monitor(input int d);
        logic        e_ir, e_lr, e_iv, e_lv, e_mw, e_mr;
        logic [31:0] e_ird, e_lrd, e_len, e_wa, e_ra, e_wd;
        int          lat;
        bit          both;
        lat = lat_of(d);
        {e_ir, e_lr, e_iv, e_lv, e_mw, e_mr} = '0;
        {e_ird, e_lrd, e_len, e_wa, e_ra, e_wd} = '0;
        if (!rst && !m_busy[d]) begin
            both = ifu_req_valid[d] && lsu_req_valid[d];
`ifdef YSYX_24100012_ARB_RR_EN
            e_ir = both ? m_last[d] : ifu_req_valid[d];
            e_lr = both ? !m_last[d] : lsu_req_valid[d];
`else
            e_ir = both ? 1'b0 : ifu_req_valid[d];
            e_lr = lsu_req_valid[d];
`endif
        end
        if (!rst && m_busy[d] && cyc == m_acc[d] + lat) begin
            e_mw  = m_wen[d];
            e_mr  = !m_wen[d];
            e_len = m_len[d];
            e_wa  = m_wen[d] ? m_addr[d] : 32'h0;
            e_ra  = m_wen[d] ? 32'h0 : m_addr[d];
            e_wd  = m_wen[d] ? m_wdata[d] : 32'h0;
        end
        if (!rst && m_busy[d] && cyc > m_acc[d] + lat) begin
            if (m_owner[d]) begin
                e_lv  = 1'b1;
                e_lrd = m_data[d];
            end else begin
                e_iv  = 1'b1;
                e_ird = m_data[d];
            end
        end
        check($sformatf("outputs d%0d cyc%0d", d, cyc), outs(d),
              {e_ir, e_lr, e_iv, e_ird, e_lv, e_lrd, e_mw, e_mr, e_len, e_wa, e_ra, e_wd});

        acc_ifu[d] = ifu_req_valid[d] && ifu_req_ready[d];
        acc_lsu[d] = lsu_req_valid[d] && lsu_req_ready[d];
        if (mem_wen[d]) phys_ram[d][mem_waddr[d][8:2]] = mem_wdata[d];

        if (rst) begin
            m_busy[d] = 1'b0;
            m_last[d] = 1'b1;
        end else if (!m_busy[d]) begin
            if ((ifu_req_valid[d] && e_ir) || (lsu_req_valid[d] && e_lr)) begin
                m_busy[d]  = 1'b1;
                m_acc[d]   = cyc;
                m_owner[d] = e_lr;
                m_last[d]  = e_lr;
                m_wen[d]   = e_lr ? lsu_wen[d] : 1'b0;
                m_addr[d]  = e_lr ? lsu_addr[d] : ifu_addr[d];
                m_wdata[d] = e_lr ? lsu_wdata[d] : 32'h0;
                m_len[d]   = e_lr ? lsu_len[d] : 32'd4;
            end
        end else if (cyc == m_acc[d] + lat) begin
            if (m_wen[d]) begin
                ref_ram[d][m_addr[d][8:2]] = m_wdata[d];
                m_data[d] = 32'h0;
            end else begin
                m_data[d] = ref_ram[d][m_addr[d][8:2]];
            end
        end else if (cyc > m_acc[d] + lat) begin
            if (m_owner[d] ? lsu_resp_ready[d] : ifu_resp_ready[d]) m_busy[d] = 1'b0;
        end
    endtask

    // Samples the current cycle 1 time unit after the falling edge, then waits for the next one.
    task automatic cycle_end();
        #1;
        for (int d = 0; d < ND; d++) monitor(d);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < ND; d++) begin
            ifu_req_valid[d]  = 1'b0;
            lsu_req_valid[d]  = 1'b0;
            ifu_resp_ready[d] = 1'b0;
            lsu_resp_ready[d] = 1'b0;
        end
    endtask

    typedef struct {
        int          d;
        bit          lsu;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] len;
        int          hold;
        logic [31:0] exp;
    } txn_t;

    typedef struct {
        bit iv;
        bit lv;
        bit ir;
        bit lr;
    } arb_t;

    task automatic run_txn(input txn_t t);
        int n;
        bit got;
        logic [31:0] rd;
        idle_inputs();
        if (t.lsu) begin
            lsu_req_valid[t.d] = 1'b1;
            lsu_wen[t.d]       = t.wen;
            lsu_addr[t.d]      = t.addr;
            lsu_wdata[t.d]     = t.wdata;
            lsu_len[t.d]       = t.len;
        end else begin
            ifu_req_valid[t.d] = 1'b1;
            ifu_addr[t.d]      = t.addr;
        end
        got = 1'b0;
        for (n = 0; n < 20 && !got; n++) begin
            cycle_end();
            got = t.lsu ? acc_lsu[t.d] : acc_ifu[t.d];
        end
        check("txn accepted", {197'd0, got}, 198'd1);
        idle_inputs();
        got = 1'b0;
        for (n = 0; n < 20 && !got; n++) begin
            got = t.lsu ? lsu_resp_valid[t.d] : ifu_resp_valid[t.d];
            if (!got) cycle_end();
        end
        check("txn resp_valid", {197'd0, got}, 198'd1);
        for (n = 0; n < t.hold; n++) cycle_end();
        rd = t.lsu ? lsu_rdata[t.d] : ifu_rdata[t.d];
        check($sformatf("txn rdata d%0d addr %0h", t.d, t.addr), {166'd0, rd}, {166'd0, t.exp});
        if (t.lsu) lsu_resp_ready[t.d] = 1'b1;
        else ifu_resp_ready[t.d] = 1'b1;
        cycle_end();
        idle_inputs();
    endtask

    txn_t tv [7];
    arb_t av [4];
    bit   grants [$];
    bit   exp_g [3];

    initial begin
        tv[0] = '{0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'd4, 0, 32'h0000_0413};
        tv[1] = '{1, 1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 32'd4, 0, 32'h0};
        tv[2] = '{1, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 32'd4, 5, 32'hDEAD_BEEF};
        tv[3] = '{2, 1'b1, 1'b1, 32'h8000_0008, 32'h0000_00AB, 32'd1, 2, 32'h0};
        tv[4] = '{2, 1'b0, 1'b0, 32'h8000_0008, 32'h0, 32'd4, 0, 32'h0000_00AB};
        tv[5] = '{0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 32'd2, 1, 32'hA5A5_0001};
        tv[6] = '{0, 1'b1, 1'b1, 32'h8000_0010, 32'h1234_5678, 32'd3, 0, 32'h0};
        av[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        av[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        av[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef YSYX_24100012_ARB_RR_EN
        av[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_g = '{1'b0, 1'b1, 1'b0};
`else
        av[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_g = '{1'b1, 1'b1, 1'b1};
`endif

        rst = 1'b1;
        idle_inputs();
        for (int d = 0; d < ND; d++) begin
            ifu_addr[d] = 32'h0; lsu_wen[d] = 1'b0; lsu_addr[d] = 32'h0;
            lsu_wdata[d] = 32'h0; lsu_len[d] = 32'h0;
            m_busy[d] = 1'b0; m_last[d] = 1'b1; m_acc[d] = 0; m_data[d] = 32'h0;
            acc_ifu[d] = 1'b0; acc_lsu[d] = 1'b0;
            for (int i = 0; i < 128; i++) begin
                phys_ram[d][i] = pre(i);
                ref_ram[d][i]  = pre(i);
            end
        end
        ifu_req_valid[0] = 1'b1;
        @(negedge clk);
        cycle_end();
        cycle_end();
        rst = 1'b0;
        #1;
        check("ifu ready after reset release", {197'd0, ifu_req_ready[0]}, 198'd1);
        ifu_req_valid[0] = 1'b0;
        cycle_end();

        for (int i = 0; i < 7; i++) run_txn(tv[i]);

        for (int i = 0; i < 4; i++) begin
            ifu_req_valid[1] = av[i].iv;
            lsu_req_valid[1] = av[i].lv;
            #1;
            check($sformatf("arb vec %0d ready", i), {196'd0, ifu_req_ready[1], lsu_req_ready[1]},
                  {196'd0, av[i].ir, av[i].lr});
            idle_inputs();
            cycle_end();
        end

        ifu_req_valid[1] = 1'b1; ifu_addr[1] = 32'h8000_0020;
        lsu_req_valid[1] = 1'b1; lsu_wen[1] = 1'b0; lsu_addr[1] = 32'h8000_0024; lsu_len[1] = 32'd4;
        ifu_resp_ready[1] = 1'b1; lsu_resp_ready[1] = 1'b1;
        for (int n = 0; n < 60 && grants.size() < 3; n++) begin
            cycle_end();
            if (acc_ifu[1]) grants.push_back(1'b0);
            if (acc_lsu[1]) grants.push_back(1'b1);
        end
        check("simultaneous grant count", {166'd0, 32'(grants.size())}, {166'd0, 32'd3});
        for (int k = 0; k < 3 && k < grants.size(); k++)
            check($sformatf("grant %0d owner_is_lsu", k), {197'd0, grants[k]}, {197'd0, exp_g[k]});
        idle_inputs();
        for (int n = 0; n < 12; n++) begin
            for (int d = 0; d < ND; d++) begin ifu_resp_ready[d] = 1'b1; lsu_resp_ready[d] = 1'b1; end
            cycle_end();
        end

        for (int n = 0; n < 1500; n++) begin
            for (int d = 0; d < ND; d++) begin
                if (!ifu_req_valid[d] || acc_ifu[d]) begin
                    ifu_req_valid[d] = ($urandom_range(0, 2) == 0);
                    ifu_addr[d] = 32'h8000_0000 + 32'($urandom_range(0, 31)) * 4;
                end
                if (!lsu_req_valid[d] || acc_lsu[d]) begin
                    lsu_req_valid[d] = ($urandom_range(0, 2) == 0);
                    lsu_wen[d]   = 1'($urandom_range(0, 1));
                    lsu_addr[d]  = 32'h8000_0000 + 32'($urandom_range(0, 31)) * 4;
                    lsu_wdata[d] = $urandom;
                    case ($urandom_range(0, 2))
                        0: lsu_len[d] = 32'd1;
                        1: lsu_len[d] = 32'd2;
                        default: lsu_len[d] = 32'd4;
                    endcase
                end
                ifu_resp_ready[d] = 1'($urandom_range(0, 1));
                lsu_resp_ready[d] = ($urandom_range(0, 3) != 0);
            end
            cycle_end();
        end

        idle_inputs();
        for (int n = 0; n < 12; n++) begin
            for (int d = 0; d < ND; d++) begin ifu_resp_ready[d] = 1'b1; lsu_resp_ready[d] = 1'b1; end
            cycle_end();
        end
        idle_inputs();
        lsu_req_valid[2] = 1'b1; lsu_wen[2] = 1'b1; lsu_addr[2] = 32'h8000_0040;
        lsu_wdata[2] = 32'hCAFE_F00D; lsu_len[2] = 32'd4;
        for (int n = 0; n < 20 && !acc_lsu[2]; n++) cycle_end();
        check("abort write accepted", {197'd0, acc_lsu[2]}, 198'd1);
        lsu_req_valid[2] = 1'b0;
        lsu_resp_ready[2] = 1'b1;
        ifu_req_valid[0] = 1'b1; ifu_addr[0] = 32'h8000_0000;
        cycle_end();
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) check($sformatf("async reset outputs d%0d", d), outs(d), 198'd0);
        cycle_end();
        cycle_end();
        rst = 1'b0;
        #1;
        check("ifu ready after abort release", {197'd0, ifu_req_ready[0]}, 198'd1);
        ifu_req_valid[0] = 1'b0;
        ifu_resp_ready[0] = 1'b1;
        for (int n = 0; n < 10; n++) cycle_end();
        check("aborted write kept ram", {166'd0, phys_ram[2][16]}, {166'd0, ref_ram[2][16]});
        check("aborted write no resp", {197'd0, lsu_resp_valid[2]}, 198'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
